fetch_prefetch_unit: RTL and testbench

FETCH_PREFETCH_UNIT -- requirements
Module: fetch_prefetch_unit

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/fetch_prefetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_prefetch_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head data reads as zero while empty.
module fetch_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [WIDTH-1:0]             wdata_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // Flush wins over any push or pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Sequential-PC instruction prefetcher: one outstanding icache request, queue to decode, redirect flush.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 64,
  parameter int unsigned       INSTR_W  = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        redirect_valid,
  input  logic [ADDR_W-1:0]           redirect_pc,
  output logic                        req_valid,
  input  logic                        req_ready,
  output logic [ADDR_W-1:0]           req_addr,
  input  logic                        rsp_valid,
  input  logic [INSTR_W-1:0]          rsp_data,
  output logic                        dec_valid,
  input  logic                        dec_ready,
  output logic [INSTR_W-1:0]          dec_instr,
  output logic [ADDR_W-1:0]           dec_pc,
  output logic [$clog2(DEPTH+1)-1:0]  queue_count
);

  localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

  fetch_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]   inflight_pc_q, inflight_pc_d;
  logic                req_fire;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_flush;
  logic                fifo_full;
  logic                fifo_empty;
  logic [ENTRY_W-1:0]  head_entry;
  logic                unused_redirect_lsb;

  assign req_fire = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_REQ;
    else       state_q <= state_d;
  end

  // A response always closes the outstanding request, even when a redirect makes it stale.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_REQ:  if (req_fire) state_d = ST_WAIT;
      ST_WAIT: begin
        if (rsp_valid)           state_d = ST_REQ;
        else if (redirect_valid) state_d = ST_DROP;
      end
      ST_DROP: if (rsp_valid) state_d = ST_REQ;
      default: state_d = ST_REQ;
    endcase
  end

  always_comb begin
    req_valid = 1'b0;
    fifo_push = 1'b0;
    case (state_q)
      ST_REQ:  req_valid = !reset && !fifo_full && !redirect_valid;
      ST_WAIT: fifo_push = rsp_valid && !redirect_valid;
      default: ;
    endcase
  end

  assign fifo_flush = redirect_valid;
  assign fifo_pop   = dec_valid && dec_ready && !redirect_valid;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid)  fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
    else if (req_fire)   fetch_pc_d = fetch_pc_q + ADDR_W'(INSTR_BYTES);
    if (req_fire) inflight_pc_d = fetch_pc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign req_addr = fetch_pc_q;

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .wdata_i ({inflight_pc_q, rsp_data}),
    .rdata_o (head_entry),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (queue_count)
  );

  assign dec_valid = !fifo_empty;
  assign dec_pc    = head_entry[ENTRY_W-1:INSTR_W];
  assign dec_instr = head_entry[INSTR_W-1:0];

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit; the bench plays the icache and decode stage.
module tb_fetch_prefetch_unit;
  import fetch_pkg::*;

  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned DEPTH   = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               req_valid;
  logic               req_ready;
  logic [ADDR_W-1:0]  req_addr;
  logic               rsp_valid;
  logic [INSTR_W-1:0] rsp_data;
  logic               dec_valid;
  logic               dec_ready;
  logic [INSTR_W-1:0] dec_instr;
  logic [ADDR_W-1:0]  dec_pc;
  logic [2:0]         queue_count;

  int checks = 0;
  int failures = 0;

  fetch_prefetch_unit #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .DEPTH    (DEPTH),
    .RESET_PC ('0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .queue_count    (queue_count)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input int i);
    return 32'hA500_0000 + 32'(i);
  endfunction

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; dec_ready = 1'b0;
    cyc();
    cyc();
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_dec_valid", 64'(dec_valid), 64'd0);
    chk("rst_count", 64'(queue_count), 64'd0);
    chk("rst_dec_pc", dec_pc, 64'd0);
    chk("rst_dec_instr", 64'(dec_instr), 64'd0);
    chk("rst_state", 64'(dut.state_q), 64'(ST_REQ));

    // Sequential fetch with a one-cycle cache and a always-ready decoder.
    reset = 1'b0; req_ready = 1'b1; dec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rsp_valid = 1'b0;
      #1;
      chk("seq_req_valid", 64'(req_valid), 64'd1);
      chk("seq_req_addr", req_addr, 64'(4 * i));
      if (i > 0) begin
        chk("seq_dec_valid", 64'(dec_valid), 64'd1);
        chk("seq_dec_pc", dec_pc, 64'(4 * (i - 1)));
        chk("seq_dec_instr", 64'(dec_instr), 64'(instr_of(i - 1)));
      end
      cyc();
      rsp_valid = 1'b1; rsp_data = instr_of(i);
      #1;
      chk("seq_wait_req_valid", 64'(req_valid), 64'd0);
      chk("seq_wait_dec_valid", 64'(dec_valid), 64'd0);
      cyc();
    end
    rsp_valid = 1'b0;
    #1;
    chk("seq_last_dec_pc", dec_pc, 64'h8);
    chk("seq_last_dec_instr", 64'(dec_instr), 64'(instr_of(2)));
    chk("seq_next_addr", req_addr, 64'hC);

    // Stall decode: the head (pc 8) stays, three more fills reach DEPTH.
    dec_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      cyc();
      rsp_valid = 1'b1; rsp_data = instr_of(3 + j);
      cyc();
      rsp_valid = 1'b0;
    end
    #1;
    chk("full_count", 64'(queue_count), 64'd4);
    chk("full_req_valid", 64'(req_valid), 64'd0);
    chk("full_head_pc", dec_pc, 64'h8);
    cyc();
    chk("full_hold_req_valid", 64'(req_valid), 64'd0);
    chk("full_hold_count", 64'(queue_count), 64'd4);
    dec_ready = 1'b1;
    cyc();
    dec_ready = 1'b0;
    #1;
    chk("pop_count", 64'(queue_count), 64'd3);
    chk("pop_head_pc", dec_pc, 64'hC);
    chk("pop_head_instr", 64'(dec_instr), 64'(instr_of(3)));
    chk("pop_req_valid", 64'(req_valid), 64'd1);
    chk("pop_req_addr", req_addr, 64'h18);

    // Redirect while a request is outstanding: response must be dropped.
    cyc();
    redirect_valid = 1'b1; redirect_pc = 64'h1002;
    #1;
    chk("redir_req_gated", 64'(req_valid), 64'd0);
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("drop_state", 64'(dut.state_q), 64'(ST_DROP));
    chk("drop_count", 64'(queue_count), 64'd0);
    chk("drop_req_valid", 64'(req_valid), 64'd0);
    cyc();
    cyc();
    rsp_valid = 1'b1; rsp_data = 32'hBAD0_0001;
    #1;
    chk("drop_rsp_req_valid", 64'(req_valid), 64'd0);
    cyc();
    rsp_valid = 1'b0;
    #1;
    chk("drop_done_state", 64'(dut.state_q), 64'(ST_REQ));
    chk("drop_done_dec_valid", 64'(dec_valid), 64'd0);
    chk("drop_done_count", 64'(queue_count), 64'd0);
    chk("drop_done_addr", req_addr, 64'h1000);
    chk("drop_done_req_valid", 64'(req_valid), 64'd1);

    // Redirect coincident with the response.
    dec_ready = 1'b1;
    cyc();
    rsp_valid = 1'b1; rsp_data = 32'hBAD0_0002;
    redirect_valid = 1'b1; redirect_pc = 64'h2000;
    cyc();
    rsp_valid = 1'b0; redirect_valid = 1'b0;
    #1;
    chk("coinc_state", 64'(dut.state_q), 64'(ST_REQ));
    chk("coinc_req_valid", 64'(req_valid), 64'd1);
    chk("coinc_addr", req_addr, 64'h2000);
    chk("coinc_dec_valid", 64'(dec_valid), 64'd0);

    // Fill three entries, then redirect while decode is trying to pop.
    dec_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      rsp_valid = 1'b1; rsp_data = instr_of(10 + k);
      cyc();
      rsp_valid = 1'b0;
    end
    #1;
    chk("pre_flush_count", 64'(queue_count), 64'd3);
    chk("pre_flush_head", dec_pc, 64'h2000);
    redirect_valid = 1'b1; redirect_pc = 64'h3000; dec_ready = 1'b1;
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("flush_count", 64'(queue_count), 64'd0);
    chk("flush_dec_valid", 64'(dec_valid), 64'd0);
    chk("flush_addr", req_addr, 64'h3000);

    // Reset mid-WAIT; the late response must be ignored.
    cyc();
    chk("rst_mid_state", 64'(dut.state_q), 64'(ST_WAIT));
    reset = 1'b1;
    cyc();
    reset = 1'b0; req_ready = 1'b0;
    rsp_valid = 1'b1; rsp_data = 32'hBAD0_0003;
    cyc();
    rsp_valid = 1'b0;
    #1;
    chk("late_rsp_count", 64'(queue_count), 64'd0);
    chk("late_rsp_dec_valid", 64'(dec_valid), 64'd0);
    chk("late_rsp_req_valid", 64'(req_valid), 64'd1);
    chk("late_rsp_addr", req_addr, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
